// File: rtl/package_settings.sv
// Shared project settings: ADC sample width used across the shaping-filter chain.
package package_settings;
    localparam int SIZE_ADC_DATA = 11;
endpackage

// File: rtl/pulse_gen_adc_source_pkg.sv
// Pulse-generator parameters: FSM state type, default pulse shape and LFSR constants.
package pulse_gen_parameters;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RISE  = 2'd1,
        DECAY = 2'd2
    } pg_state_t;

    localparam int PG_BASELINE    = 100;
    localparam int PG_RISE_SHIFT  = 2;
    localparam int PG_DECAY_SHIFT = 4;
    localparam int PG_FRAC        = 8;
    localparam int PG_PERIOD      = 1000;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/pulse_gen_lfsr.sv
// 16-bit Fibonacci LFSR with clock enable; used as a small noise source.
module pulse_gen_lfsr
    import pulse_gen_parameters::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LFSR_SEED;
        end else if (en) begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/pulse_gen_adc_source.sv
// Synthetic detector-pulse ADC source: baseline plus linear-rise / exponential-decay pulses.
// Optional dither noise on the output when PULSE_GEN_NOISE_EN is defined.
module pulse_gen_adc_source
    import package_settings::*;
    import pulse_gen_parameters::*;
#(
    parameter int BASELINE    = PG_BASELINE,
    parameter int RISE_SHIFT  = PG_RISE_SHIFT,
    parameter int DECAY_SHIFT = PG_DECAY_SHIFT,
    parameter int FRAC        = PG_FRAC,
    parameter int PERIOD      = PG_PERIOD
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trigger,
    input  logic                   auto_en,
    input  logic [SIZE_ADC_DATA:0] amplitude,
    output logic [SIZE_ADC_DATA:0] adc_data,
    output logic                   pulse_start,
    output logic                   busy,
    output logic                   missed
);

    localparam int DATA_W   = SIZE_ADC_DATA + 1;
    localparam int ACC_W    = DATA_W + FRAC + 1;
    localparam int SUM_W    = DATA_W + 3;
    localparam int RISE_LEN = 1 << RISE_SHIFT;
    localparam int RCNT_W   = RISE_SHIFT + 1;
    localparam int PCNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [ACC_W-1:0]         ACC_MAX   = '1;
    localparam logic [DATA_W-1:0]        ADC_MAX   = '1;
    localparam logic signed [SUM_W:0]    ADC_MAX_S = $signed({{(SUM_W + 1 - DATA_W){1'b0}}, ADC_MAX});
    localparam logic [DATA_W-1:0]        BASE_ADC  = DATA_W'(BASELINE);
    localparam logic [SUM_W-1:0]         BASE_SUM  = SUM_W'(BASELINE);
    localparam logic [RCNT_W-1:0]        RISE_LAST = RCNT_W'(RISE_LEN - 1);
    localparam logic [PCNT_W-1:0]        PER_LAST  = PCNT_W'(PERIOD - 1);

    function automatic logic [ACC_W-1:0] sat_add_acc(input logic [ACC_W-1:0] a,
                                                     input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? ACC_MAX : s[ACC_W-1:0];
    endfunction

    // A minimum decrement of 1 guarantees the tail reaches zero.
    function automatic logic [ACC_W-1:0] decay_acc(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] d;
        d = a >> DECAY_SHIFT;
        if (d == '0 && a != '0) begin
            d = ACC_W'(1);
        end
        return a - d;
    endfunction

    function automatic logic [DATA_W-1:0] sat_adc(input logic signed [SUM_W:0] s);
        if (s < 0) begin
            return '0;
        end else if (s > ADC_MAX_S) begin
            return ADC_MAX;
        end else begin
            return s[DATA_W-1:0];
        end
    endfunction

    pg_state_t               state, state_nx;
    logic [ACC_W-1:0]        step_p0, step_nx;
    logic [RCNT_W-1:0]       rcnt, rcnt_nx;
    logic [PCNT_W-1:0]       pcnt;
    logic                    start_nx, missed_nx;
    logic                    eff_trig;
    logic [ACC_W-1:0]        amp_ext, new_step;
    logic [ACC_W-1:0]        acc_p1, acc_nx;
    logic [SUM_W-1:0]        acc_hi;
    logic signed [SUM_W:0]   noise;
    logic signed [SUM_W:0]   sum_p1;

    assign eff_trig = trigger | (auto_en & (pcnt == PER_LAST));
    assign amp_ext  = ACC_W'(amplitude);
    assign new_step = (amp_ext << FRAC) >> RISE_SHIFT;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (!auto_en || pcnt == PER_LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PCNT_W'(1);
        end
    end

    always_comb begin
        state_nx  = state;
        step_nx   = step_p0;
        rcnt_nx   = rcnt;
        acc_nx    = acc_p1;
        start_nx  = 1'b0;
        missed_nx = 1'b0;
        case (state)
            IDLE: begin
                if (eff_trig) begin
                    state_nx = RISE;
                    step_nx  = new_step;
                    rcnt_nx  = '0;
                    start_nx = 1'b1;
                end
            end
            RISE: begin
                acc_nx  = sat_add_acc(acc_p1, step_p0);
                rcnt_nx = rcnt + RCNT_W'(1);
                if (rcnt == RISE_LAST) begin
                    state_nx = DECAY;
                end
                missed_nx = eff_trig;
            end
            DECAY: begin
                acc_nx = decay_acc(acc_p1);
                // Pile-up: the new rise builds on whatever residual remains.
                if (eff_trig) begin
                    state_nx = RISE;
                    step_nx  = new_step;
                    rcnt_nx  = '0;
                    start_nx = 1'b1;
                end else if (acc_p1 == '0) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p0: FSM control, step latch and strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            step_p0     <= '0;
            rcnt        <= '0;
            pulse_start <= 1'b0;
            missed      <= 1'b0;
        end else begin
            state       <= state_nx;
            step_p0     <= step_nx;
            rcnt        <= rcnt_nx;
            pulse_start <= start_nx;
            missed      <= missed_nx;
        end
    end

    // Stage p1: pulse accumulator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_p1 <= '0;
        end else begin
            acc_p1 <= acc_nx;
        end
    end

`ifdef PULSE_GEN_NOISE_EN
    logic [15:0] lfsr;

    pulse_gen_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .state (lfsr)
    );

    assign noise = {{(SUM_W - 2){lfsr[2]}}, lfsr[2:0]};
`else
    assign noise = '0;
`endif

    assign acc_hi = SUM_W'(acc_p1 >> FRAC);
    assign sum_p1 = $signed({1'b0, BASE_SUM + acc_hi}) + noise;

    // Stage p2: registered, saturated ADC sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adc_data <= BASE_ADC;
        end else begin
            adc_data <= sat_adc(sum_p1);
        end
    end

endmodule

// File: tb/tb_pulse_gen_adc_source.sv
// Self-checking bench for pulse_gen_adc_source (default build, noise disabled).
module tb_pulse_gen_adc_source;

    localparam int BASELINE = 100;
    localparam int PERIOD   = 1000;
    localparam int ADC_MAX  = 4095;
    localparam int ACC_MAX  = (1 << 21) - 1;
    localparam int M_IDLE   = 0;
    localparam int M_RISE   = 1;
    localparam int M_DECAY  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trigger = 1'b0;
    logic        auto_en = 1'b0;
    logic [11:0] amplitude = '0;
    logic [11:0] adc_data;
    logic        pulse_start;
    logic        busy;
    logic        missed;

    int checks = 0;
    int errors = 0;

    pulse_gen_adc_source dut (
        .clk         (clk),
        .reset       (reset),
        .trigger     (trigger),
        .auto_en     (auto_en),
        .amplitude   (amplitude),
        .adc_data    (adc_data),
        .pulse_start (pulse_start),
        .busy        (busy),
        .missed      (missed)
    );

    always #5 clk = ~clk;

    // Reference model: pulse shape from plain integer arithmetic on the pulse rules.
    int m_mode, m_left, m_step, m_acc, m_pc, m_adc;
    bit m_start, m_missed;
    logic m_eff;
    logic m_busy;
    assign m_eff  = trigger | (auto_en && m_pc == PERIOD - 1);
    assign m_busy = (m_mode != M_IDLE);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode <= M_IDLE; m_left <= 0; m_step <= 0; m_acc <= 0; m_pc <= 0;
            m_adc <= BASELINE; m_start <= 0; m_missed <= 0;
        end else begin
            m_adc    <= (BASELINE + m_acc / 256 > ADC_MAX) ? ADC_MAX : BASELINE + m_acc / 256;
            m_pc     <= (!auto_en || m_pc == PERIOD - 1) ? 0 : m_pc + 1;
            m_start  <= 0;
            m_missed <= 0;
            if (m_mode == M_RISE) begin
                m_acc  <= (m_acc + m_step > ACC_MAX) ? ACC_MAX : m_acc + m_step;
                m_left <= m_left - 1;
                if (m_left == 1) m_mode <= M_DECAY;
                if (m_eff) m_missed <= 1;
            end else begin
                if (m_mode == M_DECAY)
                    m_acc <= m_acc - ((m_acc / 16 == 0 && m_acc != 0) ? 1 : m_acc / 16);
                if (m_eff) begin
                    m_mode <= M_RISE; m_step <= int'(amplitude) * 64; m_left <= 4; m_start <= 1;
                end else if (m_mode == M_DECAY && m_acc == 0) begin
                    m_mode <= M_IDLE;
                end
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic fire(input int amp);
        amplitude = 12'(amp);
        trigger   = 1'b1;
        tick();
        trigger   = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            tick();
        end
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        checks++;
        if (adc_data !== 12'd100 || busy !== 1'b0 || pulse_start !== 1'b0 || missed !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: adc=%0d busy=%b start=%b missed=%b, want 100/0/0/0",
                     adc_data, busy, pulse_start, missed);
        end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (adc_data !== 12'd100 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_baseline cyc %0d: adc=%0d busy=%b, want 100/0", i, adc_data, busy);
            end
        end
    endtask

    task automatic test_single;
        int exp_seq [6] = '{100, 356, 612, 868, 1124, 1060};
        int prev;
        int starts;
        bit done;
        fire(1024);
        checks++;
        if (pulse_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_start: start=%b busy=%b, want 1/1", pulse_start, busy);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (int'(adc_data) != exp_seq[i]) begin
                errors++;
                $display("FAIL single_shape[%0d]: adc=%0d, want %0d", i, adc_data, exp_seq[i]);
            end
        end
        prev = int'(adc_data);
        starts = 0;
        done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (pulse_start) starts++;
            checks++;
            if (int'(adc_data) > prev || adc_data !== 12'(m_adc)) begin
                errors++;
                $display("FAIL single_decay cyc %0d: adc=%0d prev=%0d model=%0d", i, adc_data, prev, m_adc);
            end
            prev = int'(adc_data);
            if (!busy) begin done = 1'b1; break; end
        end
        checks++;
        if (!done || adc_data !== 12'd100 || starts != 0) begin
            errors++;
            $display("FAIL single_end: done=%b adc=%0d extra_starts=%0d, want 1/100/0", done, adc_data, starts);
        end
    endtask

    task automatic test_saturation;
        int peak = 0;
        bit ok;
        fire(4095);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (int'(adc_data) > peak) peak = int'(adc_data);
            checks++;
            if (adc_data !== 12'(m_adc) || (peak == ADC_MAX && adc_data < 12'd3000)) begin
                errors++;
                $display("FAIL sat_rise cyc %0d: adc=%0d model=%0d peak=%0d", i, adc_data, m_adc, peak);
            end
        end
        checks++;
        if (peak != ADC_MAX) begin
            errors++;
            $display("FAIL sat_peak: peak=%0d, want %0d", peak, ADC_MAX);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sat_idle: still busy, want idle"); end
    endtask

    task automatic test_missed;
        int exp_seq [6] = '{100, 356, 612, 868, 1124, 1060};
        int n_missed = 0;
        bit ok;
        fire(1024);
        amplitude = 12'd3000;
        trigger   = 1'b1;
        tick();
        trigger   = 1'b0;
        if (missed) n_missed++;
        checks++;
        if (int'(adc_data) != exp_seq[0]) begin
            errors++;
            $display("FAIL missed_shape[0]: adc=%0d, want %0d", adc_data, exp_seq[0]);
        end
        for (int i = 1; i < 6; i++) begin
            tick();
            if (missed) n_missed++;
            checks++;
            if (int'(adc_data) != exp_seq[i] || pulse_start !== 1'b0) begin
                errors++;
                $display("FAIL missed_shape[%0d]: adc=%0d start=%b, want %0d/0", i, adc_data, pulse_start, exp_seq[i]);
            end
        end
        checks++;
        if (n_missed != 1) begin
            errors++;
            $display("FAIL missed_count: got %0d, want 1", n_missed);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL missed_idle: still busy, want idle"); end
    endtask

    task automatic test_pileup;
        int peak = 0;
        int starts = 0;
        bit ok;
        fire(1024);
        for (int i = 0; i < 14; i++) tick();
        fire(1024);
        if (pulse_start) starts++;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (int'(adc_data) > peak) peak = int'(adc_data);
            checks++;
            if (adc_data !== 12'(m_adc) || busy !== m_busy) begin
                errors++;
                $display("FAIL pileup_track cyc %0d: adc=%0d busy=%b, model %0d/%b", i, adc_data, busy, m_adc, m_busy);
            end
        end
        checks++;
        if (peak <= 1124 || starts != 1) begin
            errors++;
            $display("FAIL pileup_peak: peak=%0d starts=%0d, want >1124 and 1", peak, starts);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pileup_idle: still busy, want idle"); end
    endtask

    task automatic test_zero_amp;
        int busy_cycles = 0;
        fire(0);
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cycles++;
            checks++;
            if (adc_data !== 12'd100) begin
                errors++;
                $display("FAIL zero_amp_adc cyc %0d: adc=%0d, want 100", i, adc_data);
            end
            tick();
        end
        checks++;
        if (busy_cycles != 5) begin
            errors++;
            $display("FAIL zero_amp_busy: busy for %0d cycles, want 5", busy_cycles);
        end
    endtask

    task automatic test_auto;
        int starts = 0;
        int first = -1;
        int second = -1;
        bit manual_done = 1'b0;
        bit ok;
        amplitude = 12'd512;
        auto_en   = 1'b1;
        for (int i = 1; i <= 2100; i++) begin
            trigger = (i > 1200 && !manual_done && m_pc == PERIOD - 1);
            if (trigger) manual_done = 1'b1;
            tick();
            if (pulse_start) begin
                starts++;
                if (first < 0) first = i; else if (second < 0) second = i;
            end
            if (i % 25 == 0) begin
                checks++;
                if (adc_data !== 12'(m_adc) || pulse_start !== m_start) begin
                    errors++;
                    $display("FAIL auto_track cyc %0d: adc=%0d start=%b, model %0d/%b", i, adc_data, pulse_start, m_adc, m_start);
                end
            end
        end
        trigger = 1'b0;
        auto_en = 1'b0;
        checks++;
        if (starts != 2 || second - first != PERIOD || !manual_done) begin
            errors++;
            $display("FAIL auto_period: starts=%0d gap=%0d manual=%b, want 2/%0d/1", starts, second - first, manual_done, PERIOD);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL auto_idle: still busy, want idle"); end
    endtask

    task automatic test_reset_mid;
        fire(2048);
        tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (adc_data !== 12'd100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: adc=%0d busy=%b, want 100/0", adc_data, busy);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (adc_data !== 12'd100 || busy !== 1'b0 || pulse_start !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_after cyc %0d: adc=%0d busy=%b start=%b, want 100/0/0", i, adc_data, busy, pulse_start);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 3000; i++) begin
            amplitude = 12'($urandom_range(0, 4095));
            trigger   = ($urandom_range(0, 29) == 0);
            tick();
            checks++;
            if (adc_data !== 12'(m_adc) || busy !== m_busy || pulse_start !== m_start || missed !== m_missed) begin
                errors++;
                $display("FAIL random cyc %0d: adc=%0d busy=%b start=%b missed=%b, model %0d/%b/%b/%b",
                         i, adc_data, busy, pulse_start, missed, m_adc, m_busy, m_start, m_missed);
            end
        end
        trigger = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_missed();
        test_pileup();
        test_zero_amp();
        test_auto();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
